clk_enable_gen: RTL and testbench

Parametrised N-channel fractional clock-enable generator that follows the system PLL. It waits for the PLL lock indication to stay stable, then produces phase-aligned, single-cycle clock-enable strobes at programmable rates for the audio, ADC and control paths. It replaces per-rate PLL outputs with NCO-based enables on one fabric clock. It reports loss of lock and restarts cleanly when lock returns.

---
 rtl/clk_enable_gen_pkg.sv | 16 +
 rtl/clk_en_nco.sv | 45 ++++
 rtl/clk_enable_gen.sv | 121 ++++++++++++
 tb/tb_clk_enable_gen.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_enable_gen_pkg.sv
// Shared types and helpers for the clock-enable generator.
package clk_enable_gen_pkg;

    // Lock-qualification FSM states.
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } lock_state_t;

    // Width needed to index n items, never less than one bit.
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_en_nco.sv
// One enable channel: increment register, phase accumulator and strobe register.
module clk_en_nco #(
    parameter int ACC_W = 32
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             run,
    input  logic             wr,
    input  logic [ACC_W-1:0] wdata,
    output logic             ce
);

    logic [ACC_W-1:0] inc_reg;
    logic [ACC_W-1:0] acc_reg;
    logic             ce_reg;
    logic [ACC_W:0]   sum_next;

    // Carry out of this sum is the strobe; the low bits wrap modulo 2^ACC_W.
    assign sum_next = {1'b0, acc_reg} + {1'b0, inc_reg};

    // Increment register: survives lock loss, only reset clears it.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            inc_reg <= '0;
        end else if (wr) begin
            inc_reg <= wdata;
        end
    end

    // Accumulate while running; otherwise hold phase at zero so all channels realign.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
            ce_reg  <= 1'b0;
        end else if (run) begin
            {ce_reg, acc_reg} <= sum_next;
        end else begin
            acc_reg <= '0;
            ce_reg  <= 1'b0;
        end
    end

    assign ce = ce_reg;

endmodule

// File: rtl/clk_enable_gen.sv
// N-channel NCO clock-enable generator gated by a qualified PLL lock.
module clk_enable_gen
    import clk_enable_gen_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int ACC_W       = 32,
    parameter int LOCK_STABLE = 1024,
    parameter int CH_W        = ch_width(NUM_CH)
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic              lost_lock_clr,
    output logic [NUM_CH-1:0] ce_o,
    output logic              ready,
    output logic              lost_lock
);

    localparam int CNT_W = ch_width(LOCK_STABLE);

    logic             meta_reg;
    logic             locked_s_reg;
    lock_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             lost_set;
    logic             lost_lock_reg;
    logic             run;

    // Two-stage synchroniser for the asynchronous lock input.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            meta_reg     <= 1'b0;
            locked_s_reg <= 1'b0;
        end else begin
            meta_reg     <= pll_locked;
            locked_s_reg <= meta_reg;
        end
    end

    // FSM state and settle counter registers.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_reg <= WAIT_LOCK;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next state: lock must hold for LOCK_STABLE settle cycles before running.
    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        lost_set   = 1'b0;
        case (state_reg)
            WAIT_LOCK: begin
                if (locked_s_reg) begin
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (!locked_s_reg) begin
                    state_next = WAIT_LOCK;
                    lost_set   = 1'b1;
                end else if (cnt_reg == CNT_W'(LOCK_STABLE - 1)) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RUN: begin
                if (!locked_s_reg) begin
                    state_next = WAIT_LOCK;
                    lost_set   = 1'b1;
                end
            end
            default: begin
                state_next = WAIT_LOCK;
            end
        endcase
    end

    // Sticky lost-lock flag; a new loss beats a simultaneous clear.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lost_lock_reg <= 1'b0;
        end else if (lost_set) begin
            lost_lock_reg <= 1'b1;
        end else if (lost_lock_clr) begin
            lost_lock_reg <= 1'b0;
        end
    end

    // Accumulate only on edges that stay in RUN: the entry edge keeps phase at
    // zero for alignment, the exit edge kills any strobe in flight.
    assign run       = (state_reg == RUN) && (state_next == RUN);
    assign ready     = (state_reg == RUN);
    assign lost_lock = lost_lock_reg;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic wr;
            assign wr = cfg_we && (cfg_ch == CH_W'(gi));
            clk_en_nco #(
                .ACC_W (ACC_W)
            ) u_nco (
                .refclk (refclk),
                .rst    (rst),
                .run    (run),
                .wr     (wr),
                .wdata  (cfg_inc),
                .ce     (ce_o[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_enable_gen.sv
// Randomised and directed bench with a lock-history / phase-sum reference model.
module tb_clk_enable_gen;

    localparam int NUM_CH      = 3;
    localparam int ACC_W       = 8;
    localparam int LOCK_STABLE = 8;
    localparam int CH_W        = 2;

    logic              refclk;
    logic              rst;
    logic              pll_locked;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [ACC_W-1:0]  cfg_inc;
    logic              lost_lock_clr;
    logic [NUM_CH-1:0] ce_o;
    logic              ready;
    logic              lost_lock;

    int err_cnt = 0;
    int chk_cnt = 0;
    logic chk_en = 1'b0;

    clk_enable_gen #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .LOCK_STABLE (LOCK_STABLE),
        .CH_W        (CH_W)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .cfg_we        (cfg_we),
        .cfg_ch        (cfg_ch),
        .cfg_inc       (cfg_inc),
        .lost_lock_clr (lost_lock_clr),
        .ce_o          (ce_o),
        .ready         (ready),
        .lost_lock     (lost_lock)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // st0/st1/st2: run length of consecutive high pll_locked samples through the
    // current, previous and second-previous sampling edge. The design is running
    // after edge e exactly when the lock was seen high for LOCK_STABLE+1 samples
    // ending two samples back (2 synchroniser stages). Strobes are the moments the
    // running phase sum crosses a multiple of 2^ACC_W.
    int                st0, st1, st2;
    logic              m_ready, m_lost;
    logic [NUM_CH-1:0] m_ce;
    longint            m_phase [NUM_CH];
    logic [ACC_W-1:0]  m_inc   [NUM_CH];
    logic              m_ready_new, m_lost_set, m_run;

    assign m_ready_new = (st1 >= LOCK_STABLE + 1);
    assign m_lost_set  = (st1 == 0) && (st2 > 0);
    assign m_run       = m_ready && m_ready_new;

    always @(posedge refclk or posedge rst) begin
        if (rst) begin
            st0     <= 0;
            st1     <= 0;
            st2     <= 0;
            m_ready <= 1'b0;
            m_lost  <= 1'b0;
            m_ce    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_phase[i] <= 0;
                m_inc[i]   <= '0;
            end
        end else begin
            st0     <= pll_locked ? st0 + 1 : 0;
            st1     <= st0;
            st2     <= st1;
            m_ready <= m_ready_new;
            m_lost  <= m_lost_set ? 1'b1 : (lost_lock_clr ? 1'b0 : m_lost);
            for (int i = 0; i < NUM_CH; i++) begin
                if (m_run) begin
                    m_phase[i] <= m_phase[i] + longint'(m_inc[i]);
                    m_ce[i]    <= (((m_phase[i] + longint'(m_inc[i])) >> ACC_W) != (m_phase[i] >> ACC_W));
                end else begin
                    m_phase[i] <= 0;
                    m_ce[i]    <= 1'b0;
                end
            end
            if (cfg_we && (int'(cfg_ch) < NUM_CH)) m_inc[cfg_ch] <= cfg_inc;
        end
    end

    // Continuous comparison away from the active edge.
    always @(negedge refclk) begin
        if (chk_en && !rst) begin
            check("ready", 32'(ready), 32'(m_ready));
            check("ce_o", 32'(ce_o), 32'(m_ce));
            check("lost_lock", 32'(lost_lock), 32'(m_lost));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge refclk);
    endtask

    task automatic cfg_write(input int ch, input int val);
        cfg_we  = 1'b1;
        cfg_ch  = CH_W'(ch);
        cfg_inc = ACC_W'(val);
        @(negedge refclk);
        cfg_we  = 1'b0;
        $display("cfg write ch=%0d inc=%0d", ch, val);
    endtask

    // Counts negedges until ready is seen; a timeout counts as a failure.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 200) begin
            @(negedge refclk);
            n++;
        end
        if (!ready) check("ready_timeout", 32'(ready), 32'd1);
    endtask

    int n;
    int cnt2;
    logic [31:0] mask0, mask1, exp0, exp1;
    int r;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        pll_locked = 1'b0;
        cfg_we = 1'b0;
        cfg_ch = '0;
        cfg_inc = '0;
        lost_lock_clr = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_ce", 32'(ce_o), 32'd0);
        check("rst_lost", 32'(lost_lock), 32'd0);
        @(negedge refclk);
        rst = 1'b0;
        chk_en = 1'b1;
        cyc(3);

        // Lock qualification with channel rates 64 / 96 / 0.
        cfg_write(0, 64);
        cfg_write(1, 96);
        cfg_write(2, 0);
        pll_locked = 1'b1;
        wait_ready(n);
        check("lock_latency", 32'(n), 32'(LOCK_STABLE + 3));
        $display("lock qualified after %0d cycles", n);

        // Strobe pattern right after RUN entry.
        mask0 = '0;
        mask1 = '0;
        for (int j = 1; j <= 16; j++) begin
            @(negedge refclk);
            mask0[j] = ce_o[0];
            mask1[j] = ce_o[1];
        end
        exp0 = (32'd1 << 4) | (32'd1 << 8) | (32'd1 << 12) | (32'd1 << 16);
        exp1 = (32'd1 << 3) | (32'd1 << 6) | (32'd1 << 8) | (32'd1 << 11) | (32'd1 << 14) | (32'd1 << 16);
        check("ch0_pattern", mask0, exp0);
        check("ch1_pattern", mask1, exp1);
        $display("strobe pattern ch0=%h ch1=%h", mask0, mask1);

        // Out-of-range channel write, then inc=0 channel silence.
        cfg_write(3, 200);
        cnt2 = 0;
        for (int j = 0; j < 1000; j++) begin
            @(negedge refclk);
            if (ce_o[2]) cnt2++;
        end
        check("inc0_silent", 32'(cnt2), 32'd0);
        $display("inc=0 channel strobes over 1000 cycles: %0d", cnt2);

        // Rewrite mid-RUN; the model tracks period and phase continuity.
        cfg_write(0, 128);
        cfg_write(1, 255);
        cfg_write(2, 1);
        cyc(300);

        // Lock loss in RUN.
        pll_locked = 1'b0;
        cyc(2);
        check("loss_ready_hold", 32'(ready), 32'd1);
        cyc(1);
        check("loss_ready", 32'(ready), 32'd0);
        check("loss_ce", 32'(ce_o), 32'd0);
        check("loss_flag", 32'(lost_lock), 32'd1);
        cyc(5);
        check("loss_sticky", 32'(lost_lock), 32'd1);
        lost_lock_clr = 1'b1;
        @(negedge refclk);
        lost_lock_clr = 1'b0;
        check("loss_cleared", 32'(lost_lock), 32'd0);
        $display("lock loss in RUN handled");

        // Glitch during SETTLE with a clear landing on the same edge as the set.
        pll_locked = 1'b1;
        cyc(6);
        pll_locked = 1'b0;
        cyc(1);
        pll_locked = 1'b1;
        cyc(1);
        lost_lock_clr = 1'b1;
        cyc(1);
        lost_lock_clr = 1'b0;
        check("glitch_set_wins", 32'(lost_lock), 32'd1);
        check("glitch_not_ready", 32'(ready), 32'd0);
        wait_ready(n);
        check("glitch_recount", 32'(n), 32'(LOCK_STABLE + 1));
        $display("settle glitch recount %0d cycles", n);

        // Randomised traffic.
        for (int j = 0; j < 3000; j++) begin
            r = int'($urandom_range(0, 399));
            if (r == 0) pll_locked = 1'b0;
            else if (!pll_locked && r < 40) pll_locked = 1'b1;
            cfg_we = ($urandom_range(0, 29) == 0);
            cfg_ch = CH_W'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: cfg_inc = 8'd255;
                1: cfg_inc = 8'd0;
                2: cfg_inc = 8'd128;
                default: cfg_inc = ACC_W'($urandom);
            endcase
            lost_lock_clr = ($urandom_range(0, 49) == 0);
            @(negedge refclk);
        end
        cfg_we = 1'b0;
        lost_lock_clr = 1'b0;
        $display("random phase done");

        // Asynchronous reset while running.
        pll_locked = 1'b1;
        cfg_write(0, 255);
        cfg_write(1, 200);
        wait_ready(n);
        cyc(5);
        @(posedge refclk);
        #2 rst = 1'b1;
        #1;
        check("arst_ready", 32'(ready), 32'd0);
        check("arst_ce", 32'(ce_o), 32'd0);
        check("arst_lost", 32'(lost_lock), 32'd0);
        @(negedge refclk);
        rst = 1'b0;
        wait_ready(n);
        check("arst_relock", 32'(n), 32'(LOCK_STABLE + 3));
        cnt2 = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge refclk);
            if (ce_o != '0) cnt2++;
        end
        check("arst_inc_cleared", 32'(cnt2), 32'd0);
        $display("async reset in RUN handled");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
